cfs_apb_irq_ctrl: RTL and testbench



---
 rtl/cfs_apb_irq_ctrl_if.sv | 27 ++
 rtl/cfs_apb_irq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cfs_apb_irq_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cfs_apb_irq_ctrl_if.sv
// APB slave bus bundle for cfs_apb_irq_ctrl.
//   master modport : drives paddr/pwrite/psel/penable/pwdata, samples pready/prdata/pslverr
//   slave modport  : the reverse
interface cfs_apb_irq_ctrl_if #(
  parameter int unsigned APB_ADDR_WIDTH = 16
) ();

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [31:0]               pwdata;
  logic                      pready;
  logic [31:0]               prdata;
  logic                      pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/cfs_apb_irq_ctrl.sv
// Parametrised APB interrupt controller.
// NUM_SRC sources with per-source trigger mode (rising / falling / level-high), sticky
// write-1-to-clear status, enable mask and WAIT_STATES extra access cycles.
//
// Ports:
//   pclk, presetn : clock, asynchronous active-low reset
//   apb           : APB slave (paddr, pwrite, psel, penable, pwdata / pready, prdata, pslverr)
//   src           : interrupt source levels, synchronous to pclk
//   irq           : combined level interrupt, |(IRQ & IRQEN)
//
// Register map (word aligned): 0x00 IRQEN, 0x04 IRQ (W1C), 0x08 MODE, 0x0C RAW (RO).
// Optional feature macro CFS_APB_IRQ_CTRL_SET_EN adds 0x10 IRQ_SET (write-only, W1S).
module cfs_apb_irq_ctrl #(
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter int unsigned NUM_SRC        = 5,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic                 pclk,
  input  logic                 presetn,
  cfs_apb_irq_ctrl_if.slave    apb,
  input  logic [NUM_SRC-1:0]   src,
  output logic                 irq
);

  localparam int unsigned ModeWidth = 2 * NUM_SRC;

  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IRQEN = APB_ADDR_WIDTH'(32'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IRQ   = APB_ADDR_WIDTH'(32'h04);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MODE  = APB_ADDR_WIDTH'(32'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_RAW   = APB_ADDR_WIDTH'(32'h0C);
`ifdef CFS_APB_IRQ_CTRL_SET_EN
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_SET   = APB_ADDR_WIDTH'(32'h10);
`endif

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [NUM_SRC-1:0]    irqen_q, irqen_d;
  logic [NUM_SRC-1:0]    stat_q, stat_d;
  logic [ModeWidth-1:0]  mode_q, mode_d;
  logic [NUM_SRC-1:0]    src_q;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [31:0]           prdata_q, prdata_d;

  logic [APB_ADDR_WIDTH-1:0] addr_word;
  logic                      acc_err;
  logic [31:0]               acc_data;
  logic                      mode_bad;
  logic [NUM_SRC-1:0]        event_vec;
  logic                      commit_wr;
  logic                      unused_bits;

  assign addr_word   = {apb.paddr[APB_ADDR_WIDTH-1:2], 2'b00};
  assign unused_bits = ^{apb.pwdata, apb.paddr[1:0]};

  // Access decode: error flag and read data for the current bus address.
  always_comb begin
    mode_bad = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (apb.pwdata[2*i +: 2] == 2'b11) mode_bad = 1'b1;
    end

    acc_err  = 1'b0;
    acc_data = '0;
    case (addr_word)
      ADDR_IRQEN: acc_data[NUM_SRC-1:0] = irqen_q;
      ADDR_IRQ:   acc_data[NUM_SRC-1:0] = stat_q;
      ADDR_MODE: begin
        if (apb.pwrite && mode_bad) acc_err = 1'b1;
        acc_data[ModeWidth-1:0] = mode_q;
      end
      ADDR_RAW: begin
        if (apb.pwrite) acc_err = 1'b1;
        acc_data[NUM_SRC-1:0] = src_q;
      end
`ifdef CFS_APB_IRQ_CTRL_SET_EN
      ADDR_SET: begin
        if (!apb.pwrite) acc_err = 1'b1;
      end
`endif
      default: acc_err = 1'b1;
    endcase
    // Read data only accompanies successful reads.
    if (acc_err || apb.pwrite) acc_data = '0;
  end

  // Access FSM. The counter holds the wait cycles still owed; pready lands in cycle
  // N+1+WAIT_STATES where N is the first cycle of psel&penable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (apb.psel && apb.penable) begin
          cnt_d = 3'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!(apb.psel && apb.penable)) begin
          state_d = StIdle;     // aborted by the master, nothing committed
          cnt_d   = 3'd0;
        end else if (cnt_q <= 3'd1) begin
          state_d = StResp;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign pready_d  = (state_d == StResp);
  assign pslverr_d = pready_d & acc_err;
  assign prdata_d  = pready_d ? acc_data : 32'd0;

  // Writes take effect on the edge that closes the pready cycle; the master holds
  // address and data stable until then.
  assign commit_wr = (state_q == StResp) && apb.pwrite && !pslverr_q;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      unique case (mode_q[2*i +: 2])
        2'd0:    event_vec[i] = src[i] & ~src_q[i];
        2'd1:    event_vec[i] = ~src[i] & src_q[i];
        2'd2:    event_vec[i] = src[i];
        default: event_vec[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    irqen_d = irqen_q;
    mode_d  = mode_q;
    stat_d  = stat_q;
    if (commit_wr && (addr_word == ADDR_IRQEN)) irqen_d = apb.pwdata[NUM_SRC-1:0];
    if (commit_wr && (addr_word == ADDR_MODE))  mode_d  = apb.pwdata[ModeWidth-1:0];
    if (commit_wr && (addr_word == ADDR_IRQ))   stat_d  = stat_q & ~apb.pwdata[NUM_SRC-1:0];
`ifdef CFS_APB_IRQ_CTRL_SET_EN
    if (commit_wr && (addr_word == ADDR_SET))   stat_d  = stat_d | apb.pwdata[NUM_SRC-1:0];
`endif
    // Applied last so a same-cycle event beats a W1C on the same bit.
    stat_d = stat_d | event_vec;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      irqen_q   <= '1;
      stat_q    <= '0;
      mode_q    <= '0;
      src_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      irqen_q   <= irqen_d;
      stat_q    <= stat_d;
      mode_q    <= mode_d;
      src_q     <= src;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  assign irq         = |(stat_q & irqen_q);

endmodule

// File: tb/tb_cfs_apb_irq_ctrl.sv
// Directed bench for cfs_apb_irq_ctrl: one instance with WAIT_STATES=0 for the register
// behaviour and one with WAIT_STATES=3 for latency and abort.
module tb_cfs_apb_irq_ctrl;

  logic       pclk;
  logic       presetn;
  logic [4:0] src0;
  logic [4:0] src3;
  logic       irq0;
  logic       irq3;

  int n_total = 0;
  int n_bad   = 0;

  cfs_apb_irq_ctrl_if #(.APB_ADDR_WIDTH(16)) bus0 ();
  cfs_apb_irq_ctrl_if #(.APB_ADDR_WIDTH(16)) bus3 ();

  cfs_apb_irq_ctrl #(.APB_ADDR_WIDTH(16), .NUM_SRC(5), .WAIT_STATES(0)) u_dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (bus0.slave),
    .src     (src0),
    .irq     (irq0)
  );

  cfs_apb_irq_ctrl #(.APB_ADDR_WIDTH(16), .NUM_SRC(5), .WAIT_STATES(3)) u_dut3 (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (bus3.slave),
    .src     (src3),
    .irq     (irq3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input bit which, input logic sel, input logic en, input logic wr,
                         input logic [15:0] addr, input logic [31:0] wdata);
    if (!which) begin
      bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr; bus0.paddr = addr;
      bus0.pwdata = wdata;
    end else begin
      bus3.psel = sel; bus3.penable = en; bus3.pwrite = wr; bus3.paddr = addr;
      bus3.pwdata = wdata;
    end
  endtask

  // Full APB transfer with a bounded wait for pready.
  task automatic apb(input bit which, input logic wr, input logic [15:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    bit seen = 0;
    rdata = 32'd0;
    err   = 1'b0;
    @(posedge pclk); #1 set_bus(which, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge pclk); #1 set_bus(which, 1'b1, 1'b1, wr, addr, wdata);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge pclk);
      if (!which && bus0.pready) begin
        seen = 1; rdata = bus0.prdata; err = bus0.pslverr;
      end else if (which && bus3.pready) begin
        seen = 1; rdata = bus3.prdata; err = bus3.pslverr;
      end
    end
    check("pready_seen", 32'(seen), 32'd1);
    @(posedge pclk); #1 set_bus(which, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic wr0(input string tag, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic exp_err);
    logic [31:0] rd;
    logic        er;
    apb(1'b0, 1'b1, addr, wdata, rd, er);
    check(tag, 32'(er), 32'(exp_err));
  endtask

  task automatic rd0(input string tag, input logic [15:0] addr, input logic [31:0] exp,
                     input logic exp_err);
    logic [31:0] rd;
    logic        er;
    apb(1'b0, 1'b0, addr, 32'h0, rd, er);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge pclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          first;
    int          n_hi;
    logic [31:0] rd;
    logic        er;

    presetn = 1'b0;
    src0    = 5'h0;
    src3    = 5'h0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset state
    cycles(2);
    check("rst_pready", 32'(bus0.pready), 32'd0);
    check("rst_pslverr", 32'(bus0.pslverr), 32'd0);
    check("rst_prdata", bus0.prdata, 32'd0);
    check("rst_irq", 32'(irq0), 32'd0);
    #2 presetn = 1'b1;

    rd0("def_irqen", 16'h00, 32'h1F, 1'b0);
    rd0("def_irq", 16'h04, 32'h00, 1'b0);
    rd0("def_mode", 16'h08, 32'h000, 1'b0);
    check("def_irq_out", 32'(irq0), 32'd0);

    // Rising edge on src[2], then W1C
    src0[2] = 1'b1;
    @(negedge pclk);
    check("rise_irq_same_cycle", 32'(irq0), 32'd0);
    @(negedge pclk);
    check("rise_irq_next", 32'(irq0), 32'd1);
    rd0("rise_stat", 16'h04, 32'h04, 1'b0);
    rd0("raw", 16'h0C, 32'h04, 1'b0);
    wr0("w1c_wr", 16'h04, 32'h04, 1'b0);
    @(negedge pclk);
    check("w1c_irq_out", 32'(irq0), 32'd0);
    rd0("w1c_stat", 16'h04, 32'h00, 1'b0);

    // Illegal MODE and RO/unmapped writes
    wr0("mode_ill_wr", 16'h08, 32'h3, 1'b1);
    rd0("mode_ill_rd", 16'h08, 32'h0, 1'b0);
    wr0("mode_ill4_wr", 16'h08, 32'h300, 1'b1);
    wr0("mode_hi_wr", 16'h08, 32'hC00, 1'b0);   // field of a nonexistent source is ignored
    rd0("mode_hi_rd", 16'h08, 32'h0, 1'b0);
    wr0("raw_wr", 16'h0C, 32'h1, 1'b1);
    wr0("unmap_wr", 16'h20, 32'h1, 1'b1);
    rd0("unmap_rd", 16'h20, 32'h0, 1'b1);

    // Level mode: set beats W1C while src is high
    wr0("mode_lvl_wr", 16'h08, 32'h200, 1'b0);
    rd0("mode_lvl_rd", 16'h08, 32'h200, 1'b0);
    src0[4] = 1'b1;
    cycles(2);
    wr0("lvl_w1c_hi", 16'h04, 32'h10, 1'b0);
    rd0("lvl_stat_hi", 16'h04, 32'h10, 1'b0);
    src0[4] = 1'b0;
    cycles(2);
    wr0("lvl_w1c_lo", 16'h04, 32'h10, 1'b0);
    rd0("lvl_stat_lo", 16'h04, 32'h00, 1'b0);

    // Mask: status still sets, irq stays low
    wr0("mask_wr", 16'h00, 32'h0, 1'b0);
    rd0("mask_rd", 16'h00, 32'h0, 1'b0);
    src0[0] = 1'b1;
    cycles(2);
    check("mask_irq_out", 32'(irq0), 32'd0);
    rd0("mask_stat", 16'h04, 32'h01, 1'b0);
    wr0("unmask_wr", 16'h00, 32'h1F, 1'b0);
    @(negedge pclk);
    check("unmask_irq_out", 32'(irq0), 32'd1);
    wr0("remask_wr", 16'h00, 32'h0, 1'b0);
    @(negedge pclk);
    check("remask_irq_out", 32'(irq0), 32'd0);
    rd0("remask_stat", 16'h04, 32'h01, 1'b0);
    wr0("irqen_all_wr", 16'h00, 32'hFFFF_FFFF, 1'b0);
    rd0("irqen_all_rd", 16'h00, 32'h1F, 1'b0);

    // Optional IRQ_SET register
`ifdef CFS_APB_IRQ_CTRL_SET_EN
    wr0("set_wr", 16'h10, 32'h02, 1'b0);
    rd0("set_stat", 16'h04, 32'h03, 1'b0);
    rd0("set_rd", 16'h10, 32'h0, 1'b1);
`else
    wr0("set_wr", 16'h10, 32'h02, 1'b1);
    rd0("set_stat", 16'h04, 32'h01, 1'b0);
`endif

    // Falling mode on src[1]
    wr0("fall_clr", 16'h04, 32'h1F, 1'b0);
    wr0("fall_mode", 16'h08, 32'h004, 1'b0);
    src0[1] = 1'b1;
    cycles(2);
    rd0("fall_rise_stat", 16'h04, 32'h00, 1'b0);
    src0[1] = 1'b0;
    cycles(2);
    rd0("fall_stat", 16'h04, 32'h02, 1'b0);

    // Reset during the pready cycle of a write discards it
    @(posedge pclk); #1 set_bus(1'b0, 1'b1, 1'b0, 1'b1, 16'h00, 32'h0);
    @(posedge pclk); #1 set_bus(1'b0, 1'b1, 1'b1, 1'b1, 16'h00, 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    check("rstmid_pready", 32'(bus0.pready), 32'd1);
    presetn = 1'b0;
    src0    = 5'h0;
    #1 check("rstmid_pready_clr", 32'(bus0.pready), 32'd0);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    cycles(2);
    #2 presetn = 1'b1;
    rd0("rstmid_irqen", 16'h00, 32'h1F, 1'b0);
    rd0("rstmid_mode", 16'h08, 32'h0, 1'b0);

    // WAIT_STATES=3 latency: first psel&penable cycle is index 0
    @(posedge pclk); #1 set_bus(1'b1, 1'b1, 1'b0, 1'b0, 16'h00, 32'h0);
    @(posedge pclk); #1 set_bus(1'b1, 1'b1, 1'b1, 1'b0, 16'h00, 32'h0);
    first = -1;
    n_hi  = 0;
    rd    = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      if (bus3.pready) begin
        n_hi++;
        if (first < 0) begin
          first = k;
          rd    = bus3.prdata;
        end
      end
    end
    check("ws_latency", 32'(first), 32'd4);
    check("ws_pready_width", 32'(n_hi), 32'd1);
    check("ws_prdata", rd, 32'h1F);
    @(posedge pclk); #1 set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    cycles(6);

    // Abort a write to IRQEN after two access cycles
    @(posedge pclk); #1 set_bus(1'b1, 1'b1, 1'b0, 1'b1, 16'h00, 32'h0);
    @(posedge pclk); #1 set_bus(1'b1, 1'b1, 1'b1, 1'b1, 16'h00, 32'h0);
    @(posedge pclk);
    @(posedge pclk); #1 set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    n_hi = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      if (bus3.pready) n_hi++;
    end
    check("abort_no_pready", 32'(n_hi), 32'd0);
    apb(1'b1, 1'b0, 16'h00, 32'h0, rd, er);
    check("abort_irqen", rd, 32'h1F);
    check("abort_rd_err", 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
